// File: rtl/life_pkg.sv
// Shared types and sizes for the 8x8 Game of Life sequencer.
package life_pkg;

    localparam int GRID_W = 64;
    localparam int GEN_W  = 16;
    localparam int DIV_W  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } life_state_t;

    typedef struct packed {
        logic hit_limit;
        logic stable;
        logic extinct;
    } life_flags_t;

endpackage

// File: rtl/life_tick_gen.sv
// Generation period timer: counts 0..max(period,1)-1 and pulses tick on the wrap cycle.
module life_tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last;

    // A period of 0 behaves like 1; ">=" lets a shrinking period wrap immediately.
    always_comb begin
        last  = (period == '0) ? '0 : period - DIV_W'(1);
        tick  = en && (cnt_q >= last);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/life_sequencer.sv
// Owns the Life grid register, sequences the external evolve datapath and
// stops on generation limit, still life or extinction.
//   state | meaning
//   IDLE  | accepts seed, single steps, waits for cmd_run
//   RUN   | free-running, commits on each tick
//   DONE  | stopped on a check, grid frozen until cmd_clear
module life_sequencer
    import life_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [GRID_W-1:0] seed_data,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_clear,
    input  logic [GEN_W-1:0]  gen_limit,
    input  logic [DIV_W-1:0]  period,
    output logic [GRID_W-1:0] dp_grid,
    input  logic [GRID_W-1:0] dp_evolve,
    output logic [GEN_W-1:0]  gen_count,
    output logic              upd,
    output logic              busy,
    output logic              done,
    output logic              hit_limit,
    output logic              stable,
    output logic              extinct
);

    life_state_t       state_q, state_d;
    logic              rdy_q;
    logic [GRID_W-1:0] grid_q, grid_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    life_flags_t       flags_q, flags_d, chk;
    logic              upd_q;
    logic              tick, tick_clr, tick_en;
    logic              seed_fire, commit, fire;

    assign tick_en  = (state_q == RUN) && cmd_run;
    assign tick_clr = cmd_clear || !tick_en;

    life_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clr    (tick_clr),
        .en     (tick_en),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        seed_fire     = (state_q == IDLE) && rdy_q && seed_valid && !cmd_clear;
        commit        = !cmd_clear &&
                        (((state_q == IDLE) && !seed_valid && cmd_step) ||
                         (tick_en && tick));
        chk.extinct   = (dp_evolve == '0);
        chk.stable    = (dp_evolve == grid_q) && !chk.extinct;
        chk.hit_limit = (gen_limit != '0) && (GEN_W'(gen_q + GEN_W'(1)) == gen_limit);
        fire          = commit && (chk != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (cmd_clear) begin
            state_d = IDLE;
        end else if (fire) begin
            state_d = DONE;
        end else begin
            case (state_q)
                IDLE:    if (!seed_valid && !cmd_step && cmd_run) state_d = RUN;
                RUN:     if (!cmd_run) state_d = IDLE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        seed_ready = rdy_q;
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
    end

    always_comb begin
        grid_d  = grid_q;
        gen_d   = gen_q;
        flags_d = flags_q;
        if (cmd_clear) begin
            grid_d  = '0;
            gen_d   = '0;
            flags_d = '0;
        end else if (seed_fire) begin
            grid_d  = seed_data;
            gen_d   = '0;
            flags_d = '0;
        end else if (commit) begin
            grid_d = dp_evolve;
            gen_d  = (&gen_q) ? gen_q : gen_q + GEN_W'(1);
            if (fire) flags_d = chk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_q  <= '0;
            gen_q   <= '0;
            flags_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            grid_q  <= grid_d;
            gen_q   <= gen_d;
            flags_q <= flags_d;
            upd_q   <= commit;
        end
    end

    assign dp_grid   = grid_q;
    assign gen_count = gen_q;
    assign upd       = upd_q;
    assign hit_limit = flags_q.hit_limit;
    assign stable    = flags_q.stable;
    assign extinct   = flags_q.extinct;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer with a behavioural Life datapath model.
module tb_life_sequencer;

    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_valid, seed_ready;
    logic [63:0] seed_data;
    logic        cmd_run, cmd_step, cmd_clear;
    logic [15:0] gen_limit;
    logic [23:0] period;
    logic [63:0] dp_grid, dp_evolve;
    logic [15:0] gen_count;
    logic        upd, busy, done, hit_limit, stable, extinct;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    life_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .cmd_clear  (cmd_clear),
        .gen_limit  (gen_limit),
        .period     (period),
        .dp_grid    (dp_grid),
        .dp_evolve  (dp_evolve),
        .gen_count  (gen_count),
        .upd        (upd),
        .busy       (busy),
        .done       (done),
        .hit_limit  (hit_limit),
        .stable     (stable),
        .extinct    (extinct)
    );

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            cnt += int'(g[rr*8+cc]);
                    end
                end
                n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb dp_evolve = life_next(dp_grid);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".seed_ready"}, seed_ready, 0);
        check({tag, ".grid"}, dp_grid, 0);
        check({tag, ".gen"}, gen_count, 0);
        check({tag, ".upd"}, upd, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".flags"}, {hit_limit, stable, extinct}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; seed_valid = 0; seed_data = '0;
        cmd_run = 0; cmd_step = 0; cmd_clear = 0;
        gen_limit = '0; period = 24'd1;
        #1;
        check_zero_outputs("reset");
        #11 reset = 1'b1;
        step_clk();
        check("rdy_after_reset", seed_ready, 1);

        // Blinker, period 1, free run
        seed_valid = 1; seed_data = BLINK_V;
        step_clk();
        check("blink.seed_load", dp_grid, BLINK_V);
        check("blink.seed_gen", gen_count, 0);
        seed_valid = 0; cmd_run = 1;
        step_clk();
        check("blink.busy", busy, 1);
        check("blink.rdy_run", seed_ready, 0);
        for (int i = 1; i <= 6; i++) begin
            step_clk();
            check("blink.grid", dp_grid, (i % 2 == 1) ? BLINK_H : BLINK_V);
            check("blink.gen", gen_count, 64'(i));
            check("blink.upd", upd, 1);
            check("blink.done", done, 0);
        end
        cmd_run = 0;
        step_clk();
        check("blink.stop_busy", busy, 0);
        check("blink.stop_gen", gen_count, 6);

        // Seed wins over step in the same cycle; then still life by step
        seed_valid = 1; seed_data = BLOCK; cmd_step = 1;
        step_clk();
        check("prio.grid", dp_grid, BLOCK);
        check("prio.gen", gen_count, 0);
        check("prio.upd", upd, 0);
        seed_valid = 0;
        step_clk();
        cmd_step = 0;
        check("still.done", done, 1);
        check("still.flags", {hit_limit, stable, extinct}, 3'b010);
        check("still.gen", gen_count, 1);
        check("still.grid", dp_grid, BLOCK);
        check("still.upd", upd, 1);
        cmd_run = 1; cmd_step = 1;
        step_clk();
        cmd_run = 0; cmd_step = 0;
        check("done.hold_gen", gen_count, 1);
        check("done.hold_done", done, 1);
        check("done.rdy", seed_ready, 0);
        cmd_clear = 1;
        step_clk();
        cmd_clear = 0;
        check("clear.done", done, 0);
        check("clear.grid", dp_grid, 0);
        check("clear.gen", gen_count, 0);
        check("clear.flags", {hit_limit, stable, extinct}, 0);
        check("clear.rdy", seed_ready, 1);

        // Extinction together with limit 1
        seed_valid = 1; seed_data = SINGLE; gen_limit = 16'd1;
        step_clk();
        seed_valid = 0; cmd_run = 1;
        step_clk();
        check("ext.busy", busy, 1);
        step_clk();
        check("ext.done", done, 1);
        check("ext.busy_off", busy, 0);
        check("ext.flags", {hit_limit, stable, extinct}, 3'b101);
        check("ext.grid", dp_grid, 0);
        check("ext.gen", gen_count, 1);
        cmd_run = 0; cmd_clear = 1; gen_limit = '0;
        step_clk();
        cmd_clear = 0;
        check("ext.clear_done", done, 0);

        // Period 5, seed ignored during RUN, drop run after 2 gens
        seed_valid = 1; seed_data = BLINK_V;
        step_clk();
        seed_valid = 0; period = 24'd5; cmd_run = 1;
        step_clk();
        for (int k = 1; k <= 10; k++) begin
            step_clk();
            check("per.gen", gen_count, 64'(k / 5));
            check("per.upd", upd, (k % 5 == 0) ? 1 : 0);
            check("per.grid", dp_grid, (k / 5 == 1) ? BLINK_H : BLINK_V);
            if (k == 3) begin
                check("per.rdy_run", seed_ready, 0);
                seed_valid = 0;
            end
            if (k == 2) begin
                seed_valid = 1; seed_data = BLOCK;
            end
        end
        cmd_run = 0;
        step_clk();
        check("per.idle_busy", busy, 0);
        check("per.idle_gen", gen_count, 2);
        check("per.idle_grid", dp_grid, BLINK_V);
        step_clk();
        check("per.hold_gen", gen_count, 2);

        // Period 0 acts as 1; then async reset mid-RUN
        period = 24'd0; cmd_run = 1;
        step_clk();
        for (int k = 1; k <= 3; k++) step_clk();
        check("p0.gen", gen_count, 5);
        check("p0.grid", dp_grid, BLINK_H);
        #2 reset = 1'b0;
        #1;
        check_zero_outputs("midrun_reset");
        cmd_run = 0;
        #2 reset = 1'b1;
        step_clk();
        check("post_reset.rdy", seed_ready, 1);
        check("post_reset.gen", gen_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
